procb_buf: RTL and testbench

Per-thread store of process_bytes (procb) records. The host-side program loader writes records into it, and the md5 engine's byte-processing stage reads them back. It is the responder end of the procb read interface: it presents a combinational lookup word, advances speculatively on lookup, and commits or rolls back on the following cycle. Each thread has its own small circular queue in distributed RAM.

---
 rtl/procb_buf.sv | 131 +++++++++++++
 tb/tb_procb_buf.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/procb_buf.sv
// Per-thread procb record store: one small circular queue per thread with a
// committed read pointer and a speculative lookup pointer (commit/rollback).

module procb_buf_thread #(
   parameter int PW = 3
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          wr_inc,
   input  logic          rd_inc,
   input  logic          lk_inc,
   input  logic          rollback,
   input  logic          flush,
   output logic [PW-1:0] wr_ptr,
   output logic [PW-1:0] rd_ptr,
   output logic [PW-1:0] lk_ptr
);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         lk_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         lk_ptr <= '0;
      end else begin
         if (wr_inc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_inc) rd_ptr <= rd_ptr + 1'b1;
         // a rollback rewinds to the committed pointer and cancels any lookup
         if (rollback)    lk_ptr <= rd_ptr;
         else if (lk_inc) lk_ptr <= lk_ptr + 1'b1;
      end
   end

endmodule

module procb_buf #(
   parameter int N_THREADS     = 12,
   parameter int N_THREADS_MSB = $clog2(N_THREADS) - 1,
   parameter int DEPTH         = 4,
   parameter int DEPTH_MSB     = $clog2(DEPTH) - 1,
   parameter int D_WIDTH       = 32
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [N_THREADS_MSB:0]   wr_thread_num,
   input  logic                     wr_en,
   input  logic [D_WIDTH-1:0]       din,
   output logic                     wr_full,
   input  logic [N_THREADS_MSB:0]   rd_thread_num,
   input  logic                     lookup_en,
   input  logic                     rd_en,
   input  logic                     rd_rst,
   output logic                     lookup_empty,
   output logic [D_WIDTH-1:0]       dout,
   output logic                     err
);

   localparam int PW = DEPTH_MSB + 2;
   localparam int TW = N_THREADS_MSB + 1;

   logic [N_THREADS-1:0][PW-1:0] wr_ptr, rd_ptr, lk_ptr;
   logic [N_THREADS-1:0]         wr_inc, rd_inc, lk_inc, rollback, flush;
   logic [D_WIDTH-1:0]           mem [N_THREADS][DEPTH];

   logic          pend_valid;
   logic [TW-1:0] pend_thread;

   logic [PW-1:0] wr_sel_wr, rd_sel_wr, wr_sel_rd, lk_sel;
   logic          flush_wr, flush_pend, do_write, do_commit, do_rollback, do_lookup;

   assign wr_sel_wr = wr_ptr[wr_thread_num];
   assign rd_sel_wr = rd_ptr[wr_thread_num];
   assign wr_sel_rd = wr_ptr[rd_thread_num];
   assign lk_sel    = lk_ptr[rd_thread_num];

   assign wr_full      = (wr_sel_wr - rd_sel_wr) == PW'(DEPTH);
   assign lookup_empty = lk_sel == wr_sel_rd;
   assign dout         = mem[rd_thread_num][lk_sel[DEPTH_MSB:0]];

   // a flush of the target thread overrides writes and pending resolution
   assign flush_wr    = rd_rst & (rd_thread_num == wr_thread_num);
   assign flush_pend  = rd_rst & (rd_thread_num == pend_thread);
   assign do_write    = wr_en & ~wr_full & ~flush_wr;
   assign do_commit   = pend_valid & rd_en & ~flush_pend;
   assign do_rollback = pend_valid & ~rd_en & ~flush_pend;
   assign do_lookup   = lookup_en & ~lookup_empty & ~rd_rst &
                        ~(do_rollback & (pend_thread == rd_thread_num));

   for (genvar t = 0; t < N_THREADS; t++) begin : g_thr
      assign wr_inc[t]   = do_write & (wr_thread_num == TW'(t));
      assign rd_inc[t]   = do_commit & (pend_thread == TW'(t));
      assign rollback[t] = do_rollback & (pend_thread == TW'(t));
      assign lk_inc[t]   = do_lookup & (rd_thread_num == TW'(t));
      assign flush[t]    = rd_rst & (rd_thread_num == TW'(t));

      procb_buf_thread #(.PW(PW)) u_thr (
         .CLK      (CLK),
         .RST      (RST),
         .wr_inc   (wr_inc[t]),
         .rd_inc   (rd_inc[t]),
         .lk_inc   (lk_inc[t]),
         .rollback (rollback[t]),
         .flush    (flush[t]),
         .wr_ptr   (wr_ptr[t]),
         .rd_ptr   (rd_ptr[t]),
         .lk_ptr   (lk_ptr[t])
      );
   end

   always_ff @(posedge CLK) begin
      if (do_write) mem[wr_thread_num][wr_sel_wr[DEPTH_MSB:0]] <= din;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pend_valid  <= 1'b0;
         pend_thread <= '0;
         err         <= 1'b0;
      end else begin
         // every pending lookup resolves on the next cycle, so only a new one keeps it set
         pend_valid  <= do_lookup;
         pend_thread <= rd_thread_num;
         if ((wr_en & wr_full & ~flush_wr) | (lookup_en & lookup_empty & ~rd_rst))
            err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_procb_buf.sv
// Randomized bench for procb_buf against a queue-per-thread reference model.

module tb_procb_buf;

   localparam int NT = 12, TW = 4, DEPTH = 4, DW = 32;

   logic          CLK = 1'b0;
   logic          RST;
   logic [TW-1:0] wr_thread_num, rd_thread_num;
   logic          wr_en, lookup_en, rd_en, rd_rst;
   logic [DW-1:0] din, dout;
   logic          wr_full, lookup_empty, err;

   always #5 CLK = ~CLK;

   procb_buf #(.N_THREADS(NT), .N_THREADS_MSB(TW-1), .DEPTH(DEPTH), .DEPTH_MSB(1),
               .D_WIDTH(DW)) dut (
      .CLK(CLK), .RST(RST), .wr_thread_num(wr_thread_num), .wr_en(wr_en), .din(din),
      .wr_full(wr_full), .rd_thread_num(rd_thread_num), .lookup_en(lookup_en),
      .rd_en(rd_en), .rd_rst(rd_rst), .lookup_empty(lookup_empty), .dout(dout), .err(err)
   );

   // model: per-thread queue of uncommitted records plus count already looked up
   logic [DW-1:0] q [NT][$];
   int            lk_off [NT];
   bit            m_pv, m_err;
   int            m_pt;
   logic [DW-1:0] taken [$];
   int            n_chk = 0, n_err = 0;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void m_reset();
      for (int t = 0; t < NT; t++) begin
         q[t].delete();
         lk_off[t] = 0;
      end
      m_pv = 0; m_pt = 0; m_err = 0;
   endfunction

   function automatic bit m_empty(input int t);
      return lk_off[t] == q[t].size();
   endfunction

   task automatic step(input int wt, input bit we, input logic [DW-1:0] d,
                       input int rt, input bit lk, input bit re, input bit rr);
      bit full, empty, flush_wr, pflush, rb, cm, lk_ok;
      @(negedge CLK);
      wr_thread_num = TW'(wt); wr_en = we; din = d;
      rd_thread_num = TW'(rt); lookup_en = lk; rd_en = re; rd_rst = rr;
      #1;
      full  = q[wt].size() == DEPTH;
      empty = m_empty(rt);
      chk("wr_full", wr_full, full);
      chk("lookup_empty", lookup_empty, empty);
      chk("err", err, m_err);
      if (!empty) chk("dout", dout, q[rt][lk_off[rt]]);
      @(posedge CLK);
      flush_wr = rr && rt == wt;
      pflush   = rr && m_pv && m_pt == rt;
      rb       = m_pv && !re && !pflush;
      cm       = m_pv && re && !pflush;
      lk_ok    = lk && !empty && !rr && !(rb && m_pt == rt);
      if (we && full && !flush_wr) m_err = 1;
      if (lk && empty && !rr) m_err = 1;
      if (lk_ok) taken.push_back(q[rt][lk_off[rt]]);
      if (cm) begin void'(q[m_pt].pop_front()); lk_off[m_pt]--; end
      if (rb) lk_off[m_pt] = 0;
      if (lk_ok) lk_off[rt]++;
      if (we && !full && !flush_wr) q[wt].push_back(d);
      if (rr) begin q[rt].delete(); lk_off[rt] = 0; end
      m_pv = lk_ok; m_pt = rt;
   endtask

   initial begin
      logic [DW-1:0] v;
      int wt, rt;
      wr_thread_num = '0; rd_thread_num = '0; din = '0;
      wr_en = 0; lookup_en = 0; rd_en = 0; rd_rst = 0;
      m_reset();
      RST = 1'b1;
      #12;
      chk("rst_empty", lookup_empty, 1'b1);
      chk("rst_full", wr_full, 1'b0);
      chk("rst_err", err, 1'b0);
      @(negedge CLK) RST = 1'b0;

      // in-order read of A, B, C from thread 5
      step(5, 1, 32'hA, 0, 0, 0, 0);
      step(5, 1, 32'hB, 0, 0, 0, 0);
      step(5, 1, 32'hC, 0, 0, 0, 0);
      taken.delete();
      step(0, 0, 0, 5, 1, 0, 0);
      step(0, 0, 0, 5, 1, 1, 0);
      step(0, 0, 0, 5, 1, 1, 0);
      step(0, 0, 0, 5, 0, 1, 0);
      #1 chk("t1_drained", lookup_empty, 1'b1);
      chk("t1_cnt", taken.size(), 3);
      if (taken.size() == 3) begin
         chk("t1_a", taken[0], 32'hA); chk("t1_b", taken[1], 32'hB); chk("t1_c", taken[2], 32'hC);
      end

      // rollback on thread 7, including a lookup cancelled by the rollback
      step(7, 1, 32'h1111, 0, 0, 0, 0);
      step(7, 1, 32'h2222, 0, 0, 0, 0);
      taken.delete();
      step(0, 0, 0, 7, 1, 0, 0);
      step(0, 0, 0, 7, 1, 0, 0);
      #1 chk("t3_back_to_x", dout, 32'h1111);
      step(0, 0, 0, 7, 1, 0, 0);
      step(0, 0, 0, 7, 1, 1, 0);
      step(0, 0, 0, 7, 0, 1, 0);
      chk("t3_cnt", taken.size(), 3);
      if (taken.size() == 3) begin
         chk("t3_x0", taken[0], 32'h1111); chk("t3_x1", taken[1], 32'h1111);
         chk("t3_y", taken[2], 32'h2222);
      end

      // commit follows pend_thread after the reader switches threads
      step(3, 1, 32'h31, 0, 0, 0, 0);
      step(3, 1, 32'h32, 0, 0, 0, 0);
      step(4, 1, 32'h41, 0, 0, 0, 0);
      step(0, 0, 0, 3, 1, 0, 0);
      step(0, 0, 0, 4, 0, 1, 0);
      #1 chk("t4_thr4", dout, 32'h41);
      step(0, 0, 0, 3, 0, 0, 0);
      #1 chk("t4_thr3", dout, 32'h32);

      // streaming through thread 0 across pointer wrap
      taken.delete();
      for (int k = 0; k < 13; k++)
         step(0, k < 10, 32'h500 + k, 0, !m_empty(0), 1, 0);
      chk("t5_cnt", taken.size(), 10);
      for (int k = 0; k < 10 && k < taken.size(); k++) chk("t5_order", taken[k], 32'h500 + k);

      // random legal traffic
      for (int i = 0; i < 400; i++) begin
         wt = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 2) : $urandom_range(0, NT-1);
         rt = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 2) : $urandom_range(0, NT-1);
         step(wt, ($urandom_range(0, 1) != 0) && q[wt].size() < DEPTH, $urandom, rt,
              ($urandom_range(0, 2) != 0) && !m_empty(rt), $urandom_range(0, 3) != 0,
              $urandom_range(0, 31) == 0);
      end

      // flush sweep with a pending lookup and a same-cycle write
      for (int t = 0; t < NT; t++) if (q[t].size() < DEPTH) step(t, 1, $urandom, 0, 0, 0, 0);
      step(0, 0, 0, 0, !m_empty(0), 0, 0);
      for (int t = 0; t < NT; t++) step(t, t == 6, 32'hDEAD, t, 0, 1, 1);
      for (int t = 0; t < NT; t++) begin
         step(0, 0, 0, t, 0, 0, 0);
         #1 chk("swept_empty", lookup_empty, 1'b1);
      end
      chk("sweep_err", err, 1'b0);

      // fill thread 2, overflow, then release one slot
      for (int k = 0; k < 4; k++) step(2, 1, 32'h200 + k, 0, 0, 0, 0);
      step(2, 1, 32'h2FF, 0, 0, 0, 0);
      #1 chk("ovf_err", err, 1'b1);
      chk("ovf_full", wr_full, 1'b1);
      step(2, 0, 0, 2, 1, 0, 0);
      #1 chk("spec_still_full", wr_full, 1'b1);
      step(2, 0, 0, 2, 0, 1, 0);
      #1 chk("full_release", wr_full, 1'b0);
      step(2, 0, 0, 2, 0, 0, 0);

      // asynchronous reset mid-operation
      step(1, 1, 32'h77, 0, 0, 0, 0);
      step(0, 0, 0, 1, 1, 0, 0);
      @(negedge CLK);
      wr_en = 0; lookup_en = 0; rd_en = 0; rd_rst = 0; rd_thread_num = 4'd1; wr_thread_num = 4'd2;
      RST = 1'b1;
      #1;
      chk("mid_rst_empty", lookup_empty, 1'b1);
      chk("mid_rst_full", wr_full, 1'b0);
      chk("mid_rst_err", err, 1'b0);
      m_reset();
      @(negedge CLK) RST = 1'b0;
      v = 32'hABCD;
      step(1, 1, v, 1, 0, 0, 0);
      step(0, 0, 0, 1, 1, 0, 0);
      step(0, 0, 0, 1, 0, 1, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
